// File: rtl/w_schedule_expander_if.sv
// Block/slot handshake and packed schedule RAM write port of w_schedule_expander.
interface w_schedule_expander_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned L          = 8
);
  localparam int unsigned SW = $clog2(L);

  logic [511:0]             i_block;
  logic [SW-1:0]            i_slot;
  logic                     i_valid;
  logic                     o_ready;
  logic [DATA_WIDTH*64-1:0] o_w_bus;
  logic [SW-1:0]            o_hash_address;
  logic                     o_WE;
  logic                     o_done;
  logic                     o_busy;

  modport master (
    output i_block, i_slot, i_valid,
    input  o_ready, o_w_bus, o_hash_address, o_WE, o_done, o_busy
  );

  modport slave (
    input  i_block, i_slot, i_valid,
    output o_ready, o_w_bus, o_hash_address, o_WE, o_done, o_busy
  );
endinterface

// File: rtl/w_schedule_expander.sv
// SHA-256 message schedule expander: one 512-bit block -> W0..W63 written to a RAM slot in one strobe.
// Optional macro W_EXPAND_2X_EN: two schedule words per cycle (24-cycle expansion).
module w_schedule_expander #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned L          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  w_schedule_expander_if.slave  bus
);
  localparam int unsigned SW = $clog2(L);

  typedef enum logic [1:0] {IDLE, EXPAND, WRITE} state_e;

  state_e                state_q;
  logic [5:0]            t_q;
  logic [DATA_WIDTH-1:0] w_q [64];
  logic [SW-1:0]         slot_q;
  logic                  ready_q;
  logic                  we_q;
  logic                  done_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] w0_d;
`ifdef W_EXPAND_2X_EN
  logic [DATA_WIDTH-1:0] w1_d;
`endif

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W[t+1] only reaches back to W[t-1], so both words come from already-stored entries.
  always_comb begin
    w0_d = sig1(w_q[t_q - 6'd2]) + w_q[t_q - 6'd7] + sig0(w_q[t_q - 6'd15]) + w_q[t_q - 6'd16];
`ifdef W_EXPAND_2X_EN
    w1_d = sig1(w_q[t_q - 6'd1]) + w_q[t_q - 6'd6] + sig0(w_q[t_q - 6'd14]) + w_q[t_q - 6'd15];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      slot_q  <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned k = 0; k < 64; k++) w_q[k] <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.i_valid && ready_q) begin
            for (int unsigned k = 0; k < 16; k++) w_q[k] <= bus.i_block[(15 - k) * 32 +: 32];
            slot_q  <= bus.i_slot;
            t_q     <= 6'd16;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          w_q[t_q] <= w0_d;
`ifdef W_EXPAND_2X_EN
          w_q[t_q + 6'd1] <= w1_d;
          t_q <= t_q + 6'd2;
          if (t_q == 6'd62) begin
`else
          t_q <= t_q + 6'd1;
          if (t_q == 6'd63) begin
`endif
            state_q <= WRITE;
            we_q    <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        WRITE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < 64; k++) begin : g_bus
    assign bus.o_w_bus[k*DATA_WIDTH +: DATA_WIDTH] = w_q[k];
  end

  assign bus.o_ready        = ready_q;
  assign bus.o_hash_address = slot_q;
  assign bus.o_WE           = we_q;
  assign bus.o_done         = done_q;
  assign bus.o_busy         = busy_q;
endmodule
